// File: rtl/run_monitor_pkg.sv
// Shared types for the run supervisor: FSM state and verdict fail codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    NO_VLD   = 2'd1,
    TIMEOUT  = 2'd2,
    MISALIGN = 2'd3
  } fail_code_e;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run supervisor for the CPU test flow: DUT reset sequencing, run counters,
// halt-loop / misalignment / timeout detection and a latched verdict.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int REPORT_PERIOD  = 100,
  parameter int STALL_CYCLES   = 16,
  parameter int HALT_REQUIRED  = 1,
  parameter int N_CH           = 4,
  parameter int CNT_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_dut_rst_n,
  input  logic [31:0]           i_pc,
  input  logic                  i_insn_vld,
  input  logic [N_CH-1:0]       i_event,
  output logic [1:0]            o_state,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [1:0]            o_fail_code,
  output logic [CNT_W-1:0]      o_cycle_cnt,
  output logic [CNT_W-1:0]      o_insn_cnt,
  output logic [N_CH*CNT_W-1:0] o_evt_cnt,
  output logic                  o_report_stb
);

  mon_state_e state, next_state;
  fail_code_e fail_code_q, next_code;

  logic             dut_rst_n_q, done_q, pass_q, report_stb_q;
  logic [31:0]      pc_q;
  logic             pc_vld;
  logic [CNT_W-1:0] hold_q, stall_q, cycle_q, insn_q;
  logic             in_run, in_hold, pc_match, misalign, halt_hit, timeout_hit;
  logic             hold_last, rpt_wrap;

  assign in_run      = (state == RUN);
  assign in_hold     = (state == HOLD);
  assign hold_last   = (hold_q == CNT_W'(RST_CYCLES - 1));
  assign pc_match    = i_insn_vld && pc_vld && (i_pc == pc_q);
  assign misalign    = i_insn_vld && (i_pc[1:0] != 2'b00);
  // A match that brings the run of equal PCs to STALL_CYCLES declares halt.
  assign halt_hit    = pc_match && (stall_q == CNT_W'(STALL_CYCLES - 2));
  // Wide compare so a narrow CNT_W never aliases onto the timeout value.
  assign timeout_hit = (64'(cycle_q) == 64'(TIMEOUT_CYCLES - 1));

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk(i_clk), .clr(i_rst), .en(in_hold), .q(hold_q)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(i_clk), .clr(i_rst), .en(in_run), .q(cycle_q)
  );

  sat_counter #(.W(CNT_W)) u_insn_cnt (
    .clk(i_clk), .clr(i_rst), .en(in_run && i_insn_vld), .q(insn_q)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(i_clk),
    .clr(i_rst || (in_run && i_insn_vld && !pc_match)),
    .en (in_run && pc_match),
    .q  (stall_q)
  );

  for (genvar k = 0; k < N_CH; k++) begin : g_evt
    sat_counter #(.W(CNT_W)) u_evt_cnt (
      .clk(i_clk), .clr(i_rst), .en(in_run && i_event[k]),
      .q  (o_evt_cnt[k*CNT_W +: CNT_W])
    );
  end

  if (REPORT_PERIOD > 0) begin : g_rpt
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPORT_PERIOD - 1);
    logic [CNT_W-1:0] rpt_q;
    assign rpt_wrap = in_run && (rpt_q == RPT_LAST);
    sat_counter #(.W(CNT_W)) u_rpt_cnt (
      .clk(i_clk), .clr(i_rst || rpt_wrap), .en(in_run), .q(rpt_q)
    );
  end else begin : g_no_rpt
    assign rpt_wrap = 1'b0;
  end

  always_comb begin
    next_state = state;
    next_code  = fail_code_q;
    unique case (state)
      HOLD: begin
        if (hold_last) next_state = RUN;
      end
      RUN: begin
        if (misalign) begin
          next_state = FAIL;
          next_code  = MISALIGN;
        end else if (halt_hit) begin
          next_state = PASS;
        end else if (timeout_hit) begin
          if (insn_q == '0) begin
            next_state = FAIL;
            next_code  = NO_VLD;
          end else if (HALT_REQUIRED != 0) begin
            next_state = FAIL;
            next_code  = TIMEOUT;
          end else begin
            next_state = PASS;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= HOLD;
      dut_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= NONE;
      report_stb_q <= 1'b0;
      pc_vld       <= 1'b0;
    end else begin
      state        <= next_state;
      dut_rst_n_q  <= (next_state != HOLD);
      done_q       <= (next_state == PASS) || (next_state == FAIL);
      pass_q       <= (next_state == PASS);
      fail_code_q  <= (next_state == FAIL) ? next_code : NONE;
      // The strobe that would coincide with the verdict is dropped.
      report_stb_q <= rpt_wrap && (next_state == RUN);
      if (in_run && i_insn_vld) pc_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (in_run && i_insn_vld) pc_q <= i_pc;
  end

  assign o_state      = state;
  assign o_dut_rst_n  = dut_rst_n_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_fail_code  = fail_code_q;
  assign o_cycle_cnt  = cycle_q;
  assign o_insn_cnt   = insn_q;
  assign o_report_stb = report_stb_q;

endmodule
